// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI write-channel arbiter.
package axi_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // AXI B-channel response codes used by the arbiter.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the first set request at or after
// i_ptr wins, wrapping from N_REQ-1 back to 0 (also for non-power-of-two N_REQ).
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant_oh,
  output logic [IDX_W-1:0] o_grant_idx
);

  logic w_found;

  // Scan requesters starting from the pointer; the first hit is the winner.
  always_comb begin : p_select
    int w_idx;
    o_grant_oh  = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % N_REQ;
      if (!w_found && i_req[w_idx]) begin
        w_found            = 1'b1;
        o_grant_oh[w_idx]  = 1'b1;
        o_grant_idx        = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// N-to-1 arbiter for the AXI W and B channels. One requester owns the slave
// from grant until its B response completes (or times out into SLVERR).
//
// Handshake rule on every channel: a beat transfers on the rising edge where
// valid and ready are both high; valid never depends on ready. The owner's
// valid/ready pairs are wired straight through, so the arbiter adds no
// register stage inside a phase. Non-owners always see ready=0 / bvalid=0.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  input  logic [N_REQ-1:0]          req_wvalid,
  output logic [N_REQ-1:0]          req_wready,
  output logic [1:0]                req_bresp,
  output logic [N_REQ-1:0]          req_bvalid,
  input  logic [N_REQ-1:0]          req_bready,
  output logic [DATA_W-1:0]         m_wdata,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic [7:0]                err_cnt
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [7:0]         r_err_cnt;

  logic [N_REQ-1:0]   w_win_oh;
  logic [IDX_W-1:0]   w_win_idx;
  logic [IDX_W-1:0]   w_next_ptr;
  logic [N_REQ-1:0]   w_own_oh;
  logic [DATA_W-1:0]  w_own_wdata;
  logic               w_own_wvalid;
  logic               w_own_bready;
  logic               w_any_req;
  logic               w_w_hs;
  logic               w_b_hs;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req       (req_wvalid),
    .i_ptr       (r_rr_ptr),
    .o_grant_oh  (w_win_oh),
    .o_grant_idx (w_win_idx)
  );

  assign w_any_req  = |w_win_oh;
  assign w_next_ptr = (r_grant == IDX_LAST) ? '0 : r_grant + IDX_W'(1);

  // Pick out the owner's one-hot mask and its request-side signals.
  always_comb begin
    w_own_oh     = '0;
    w_own_wdata  = '0;
    w_own_wvalid = 1'b0;
    w_own_bready = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant == IDX_W'(i)) begin
        w_own_oh[i]  = 1'b1;
        w_own_wdata  = req_wdata[i*DATA_W +: DATA_W];
        w_own_wvalid = req_wvalid[i];
        w_own_bready = req_bready[i];
      end
    end
  end

  assign w_w_hs = (r_state == ST_DATA) && w_own_wvalid && m_wready;
  assign w_b_hs = (r_state == ST_RESP) && m_bvalid && w_own_bready;

  // Route the owner's channels; everything is quiet in IDLE and during reset.
  always_comb begin
    req_wready = '0;
    req_bvalid = '0;
    req_bresp  = RESP_OKAY;
    m_wdata    = '0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_DATA: begin
          m_wdata    = w_own_wdata;
          m_wvalid   = w_own_wvalid;
          req_wready = w_own_oh & {N_REQ{m_wready}};
        end
        ST_RESP: begin
          req_bvalid = w_own_oh & {N_REQ{m_bvalid}};
          req_bresp  = m_bresp;
          m_bready   = w_own_bready;
        end
        ST_ERR: begin
          // Synthesised SLVERR; the slave's B channel is ignored here.
          req_bvalid = w_own_oh;
          req_bresp  = RESP_SLVERR;
        end
        default: ;
      endcase
    end
  end

  // FSM, round-robin pointer, response timeout and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_tmo_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_win_idx;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          // A dropped owner wvalid simply keeps us waiting here.
          if (w_w_hs) begin
            r_state   <= ST_RESP;
            r_tmo_cnt <= '0;
          end
        end
        ST_RESP: begin
          if (w_b_hs) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= w_next_ptr;
          end else if (!m_bvalid) begin
            if (r_tmo_cnt == TMO_LAST) begin
              r_state <= ST_ERR;
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
          end
        end
        ST_ERR: begin
          if (w_own_bready) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != ST_IDLE);
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_axi_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TMO = 255;

  logic              clk;
  logic              rst;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      req_wvalid;
  logic [N-1:0]      req_wready;
  logic [1:0]        req_bresp;
  logic [N-1:0]      req_bvalid;
  logic [N-1:0]      req_bready;
  logic [DW-1:0]     m_wdata;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic [1:0]        grant_id;
  logic              busy;
  logic [7:0]        err_cnt;

  axi_wr_arbiter #(
    .N_REQ       (N),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_wdata  (req_wdata),
    .req_wvalid (req_wvalid),
    .req_wready (req_wready),
    .req_bresp  (req_bresp),
    .req_bvalid (req_bvalid),
    .req_bready (req_bready),
    .m_wdata    (m_wdata),
    .m_wvalid   (m_wvalid),
    .m_wready   (m_wready),
    .m_bresp    (m_bresp),
    .m_bvalid   (m_bvalid),
    .m_bready   (m_bready),
    .grant_id   (grant_id),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_bad   = 0;

  // Reference model: who owns the slave and which phase of its write it is in
  // (0 = W beat pending, 1 = waiting for B, 2 = timed out).
  int          mdl_own;
  int          mdl_ph;
  int          mdl_rr;
  int          mdl_low;
  int          mdl_err;
  int          mdl_tmo_events;
  logic [DW-1:0] exp_q[$];
  int          grant_log[$];
  bit          accepted[N];

  // Slave agent state.
  bit          slv_pend;
  int          slv_dly;
  logic [1:0]  slv_resp;

  // Stimulus knobs (percent probabilities).
  logic [N-1:0] k_mask;
  int k_req, k_drop, k_bready, k_wready, k_dly_min, k_dly_max;
  bit k_never, k_resp_rand;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h time=%0t", tag, got, exp, $time);
    end
  endtask

  // Round-robin rule: among requesting indices, the one with the smallest
  // forward distance from the pointer wins.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    int best, best_d, d;
    best = -1;
    best_d = N;
    for (int i = 0; i < N; i++) begin
      d = (i - p + N) % N;
      if (v[i] && d < best_d) begin
        best = i;
        best_d = d;
      end
    end
    return best;
  endfunction

  task automatic release_owner();
    mdl_rr   = (mdl_own + 1) % N;
    mdl_own  = -1;
    slv_pend = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_bready[i] = ($urandom_range(99, 0) < k_bready);
      if (accepted[i]) begin
        req_wvalid[i] = 1'b0;
        accepted[i] = 1'b0;
      end
      if (mdl_own == i && mdl_ph == 0) continue;
      if (req_wvalid[i]) begin
        if (mdl_own >= 0 && $urandom_range(99, 0) < k_drop) req_wvalid[i] = 1'b0;
      end else if (k_mask[i] && $urandom_range(99, 0) < k_req) begin
        req_wvalid[i] = 1'b1;
        req_wdata[i*DW +: DW] = $urandom();
      end
    end
    m_wready = ($urandom_range(99, 0) < k_wready);
    m_bresp  = slv_resp;
    if (slv_pend && !k_never) begin
      if (slv_dly > 0) begin
        slv_dly--;
        m_bvalid = 1'b0;
      end else begin
        m_bvalid = 1'b1;
      end
    end else begin
      m_bvalid = 1'b0;
    end
  endtask

  // ---------------- model check (inputs settled, before the rising edge) ----------------
  task automatic model_check();
    logic [N-1:0] om;
    om = '0;
    check_eq("err_cnt", 32'(err_cnt), mdl_err);
    if (rst) begin
      check_eq("rst_quiet", 32'({m_wvalid, m_bready, req_wready, req_bvalid}), 0);
      mdl_own = -1; mdl_ph = 0; mdl_rr = 0; mdl_low = 0; mdl_err = 0;
      exp_q.delete();
      slv_pend = 1'b0;
      return;
    end
    if (mdl_own < 0) begin
      check_eq("idle_quiet", 32'({busy, m_wvalid, m_bready, req_wready, req_bvalid}), 0);
      if (req_wvalid != '0) begin
        mdl_own = rr_pick(req_wvalid, mdl_rr);
        mdl_ph  = 0;
        exp_q.push_back(req_wdata[mdl_own*DW +: DW]);
        grant_log.push_back(mdl_own);
      end
      return;
    end
    om[mdl_own] = 1'b1;
    check_eq("busy", 32'(busy), 1);
    check_eq("grant_id", 32'(grant_id), mdl_own);
    check_eq("nonowner_quiet", 32'((req_wready | req_bvalid) & ~om), 0);
    case (mdl_ph)
      0: begin
        check_eq("m_wvalid", 32'(m_wvalid), 32'(req_wvalid[mdl_own]));
        check_eq("wready_fwd", 32'(req_wready[mdl_own]), 32'(m_wready));
        check_eq("b_quiet_w", 32'({m_bready, req_bvalid}), 0);
        if (req_wvalid[mdl_own] && m_wready) begin
          check_eq("wdata", m_wdata, exp_q.pop_front());
          accepted[mdl_own] = 1'b1;
          mdl_ph   = 1;
          mdl_low  = 0;
          slv_pend = 1'b1;
          slv_dly  = $urandom_range(k_dly_max, k_dly_min);
          slv_resp = k_resp_rand ? 2'($urandom_range(3, 0)) : 2'b00;
        end
      end
      1: begin
        check_eq("bvalid_fwd", 32'(req_bvalid[mdl_own]), 32'(m_bvalid));
        check_eq("m_bready", 32'(m_bready), 32'(req_bready[mdl_own]));
        check_eq("w_quiet_b", 32'({m_wvalid, req_wready}), 0);
        if (m_bvalid) check_eq("bresp", 32'(req_bresp), 32'(slv_resp));
        if (m_bvalid && req_bready[mdl_own]) begin
          release_owner();
        end else if (!m_bvalid) begin
          mdl_low++;
          if (mdl_low == TMO) begin
            mdl_ph = 2;
            slv_pend = 1'b0;
            if (mdl_err < 255) mdl_err++;
            mdl_tmo_events++;
          end
        end
      end
      default: begin
        check_eq("err_bvalid", 32'(req_bvalid[mdl_own]), 1);
        check_eq("err_bresp", 32'(req_bresp), 32'h2);
        check_eq("err_bready", 32'(m_bready), 0);
        check_eq("w_quiet_e", 32'({m_wvalid, req_wready}), 0);
        if (req_bready[mdl_own]) release_owner();
      end
    endcase
  endtask

  // One clock: drive at the falling edge, check 1ns later, move to next falling edge.
  task automatic cycle();
    drive();
    #1;
    model_check();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic set_knobs(input logic [N-1:0] mask, input int req, input int drop,
                           input int bready, input int wready, input int dmin, input int dmax);
    k_mask = mask; k_req = req; k_drop = drop; k_bready = bready; k_wready = wready;
    k_dly_min = dmin; k_dly_max = dmax;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int guard;
    rst = 1'b1;
    req_wdata = '0; req_wvalid = '0; req_bready = '0;
    m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
    mdl_own = -1; mdl_ph = 0; mdl_rr = 0; mdl_low = 0; mdl_err = 0; mdl_tmo_events = 0;
    slv_pend = 1'b0; slv_dly = 0; slv_resp = 2'b00;
    k_never = 1'b0; k_resp_rand = 1'b0;
    for (int i = 0; i < N; i++) accepted[i] = 1'b0;
    set_knobs('0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset state
    do_reset();
    check_eq("rst_grant", 32'(grant_id), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_errcnt", 32'(err_cnt), 0);
    cycle();

    // Single write from requester 0, OKAY two cycles later
    set_knobs('0, 0, 0, 100, 100, 2, 2);
    grant_log.delete();
    req_wdata[0 +: DW] = 32'hDEADBEEF;
    req_wvalid[0] = 1'b1;
    cycle();
    guard = 0;
    while (mdl_own >= 0 && guard < 20) begin cycle(); guard++; end
    check_eq("s1_done", 32'(guard < 20), 1);
    check_eq("s1_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) check_eq("s1_owner", grant_log[0], 0);
    cycle();
    check_eq("s1_busy_low", 32'(busy), 0);

    // All four requesting continuously from reset
    req_wvalid = '0;
    set_knobs('1, 100, 0, 100, 100, 0, 1);
    do_reset();
    grant_log.delete();
    guard = 0;
    while (grant_log.size() < 5 && guard < 200) begin cycle(); guard++; end
    check_eq("s2_reached", 32'(grant_log.size() >= 5), 1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      check_eq($sformatf("s2_order%0d", k), grant_log[k], k % N);

    // Requester 1 arrives while requester 2 waits for its response
    set_knobs('0, 0, 0, 100, 100, 6, 6);
    req_wvalid = '0;
    do_reset();
    grant_log.delete();
    req_wdata[2*DW +: DW] = $urandom();
    req_wvalid[2] = 1'b1;
    guard = 0;
    while (!(mdl_own == 2 && mdl_ph == 1) && guard < 20) begin cycle(); guard++; end
    check_eq("s3_in_resp", 32'(mdl_own == 2 && mdl_ph == 1), 1);
    req_wdata[1*DW +: DW] = $urandom();
    req_wvalid[1] = 1'b1;
    guard = 0;
    while (grant_log.size() < 2 && guard < 40) begin cycle(); guard++; end
    check_eq("s3_regrant", 32'(grant_log.size()), 2);
    if (grant_log.size() >= 2) begin
      check_eq("s3_first", grant_log[0], 2);
      check_eq("s3_second", grant_log[1], 1);
    end
    guard = 0;
    while ((mdl_own >= 0 || req_wvalid != '0) && guard < 40) begin cycle(); guard++; end

    // Reset pulse during DATA with the slave stalling
    set_knobs('0, 0, 0, 100, 0, 0, 0);
    grant_log.delete();
    req_wdata[1*DW +: DW] = $urandom();
    req_wdata[3*DW +: DW] = $urandom();
    req_wvalid[1] = 1'b1;
    req_wvalid[3] = 1'b1;
    cycle();
    cycle();
    check_eq("s4_pre_owner", mdl_own, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check_eq("s4_regrant_low", grant_log[grant_log.size()-1], 1);
    k_wready = 100;
    guard = 0;
    while ((mdl_own >= 0 || req_wvalid != '0) && guard < 60) begin cycle(); guard++; end
    check_eq("s4_drained", 32'(guard < 60), 1);

    // Slave never responds: timeout to SLVERR, then saturation
    set_knobs(4'b0010, 100, 0, 100, 100, 0, 0);
    k_never = 1'b1;
    req_wvalid = '0;
    do_reset();
    mdl_tmo_events = 0;
    guard = 0;
    while (mdl_tmo_events < 1 && guard < 400) begin cycle(); guard++; end
    check_eq("s5_first_tmo_cycles", guard, 1 + 1 + TMO);
    cycle();
    check_eq("s5_err1", 32'(err_cnt), 1);
    guard = 0;
    while (mdl_tmo_events < 256 && guard < 70000) begin cycle(); guard++; end
    check_eq("s5_256_tmo", mdl_tmo_events, 256);
    cycle();
    cycle();
    check_eq("s5_sat", 32'(err_cnt), 255);
    k_never = 1'b0;

    // Randomized traffic
    req_wvalid = '0;
    k_resp_rand = 1'b1;
    set_knobs('1, 30, 10, 60, 60, 0, 3);
    do_reset();
    for (int c = 0; c < 3000; c++) cycle();
    k_mask = '0;
    k_drop = 0;
    guard = 0;
    while ((mdl_own >= 0 || req_wvalid != '0) && guard < 300) begin cycle(); guard++; end
    check_eq("rand_drained", 32'(guard < 300), 1);
    check_eq("rand_expq_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of write requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the W-channel data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 255, giving the maximum number of cycles to wait for B after W.
REQ-004 The block SHALL have the following ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_wdata  in  N_REQ*DATA_W  requester write data; slice i belongs to requester i.
- req_wvalid  in  N_REQ  requester write-valid.
- req_wready  out  N_REQ  requester write-ready.
- req_bresp  out  2  write response, shared; meaningful only where req_bvalid is set.
- req_bvalid  out  N_REQ  requester response-valid.
- req_bready  in  N_REQ  requester response-ready.
- m_wdata  out  DATA_W  downstream (slave) write data.
- m_wvalid  out  1  downstream write-valid.
- m_wready  in  1  downstream write-ready.
- m_bresp  in  2  downstream write response.
- m_bvalid  in  1  downstream response-valid.
- m_bready  out  1  downstream response-ready.
- grant_id  out  $clog2(N_REQ)  index of the current owner.
- busy  out  1  high in any state other than IDLE.
- err_cnt  out  8  timeout count, saturating at 255.

Function
REQ-005 The block SHALL implement a four-state FSM with states IDLE, DATA, RESP and ERR.
REQ-006 IDLE behaviour:
- No outputs are asserted toward either side.
- If any req_wvalid is set, round-robin selects a winner: the first set bit at or after rr_ptr, wrapping at N_REQ.
- On that edge, grant_id is registered to the winner and the FSM moves to DATA.
REQ-007 DATA behaviour:
- m_wdata and m_wvalid SHALL be the combinational pass-through of the granted slice.
- req_wready[grant_id] SHALL equal m_wready.
- On m_wvalid && m_wready, the FSM moves to RESP and the timeout counter clears.
REQ-008 RESP behaviour:
- req_bvalid[grant_id] SHALL equal m_bvalid, req_bresp SHALL equal m_bresp, and m_bready SHALL equal req_bready[grant_id].
- On m_bvalid && m_bready, the FSM moves to IDLE and rr_ptr becomes (grant_id+1) mod N_REQ.
REQ-009 RESP timeout:
- The timeout counter SHALL increment on each RESP cycle with m_bvalid low.
- When the counter reaches TIMEOUT_CYC-1 with m_bvalid still low, the FSM moves to ERR and err_cnt increments, saturating at 255.
REQ-010 ERR behaviour:
- req_bvalid[grant_id]=1 and req_bresp=2'b10 (SLVERR).
- m_bready=0; any m_bvalid is ignored.
- On req_bready[grant_id], the FSM moves to IDLE and rr_ptr advances as in REQ-008.
REQ-011 Non-granted requesters SHALL see req_wready=0 and req_bvalid=0 in every state.
REQ-012 Ownership SHALL be held from grant until the B handshake completes; no other requester is granted in DATA, RESP or ERR.
REQ-013 Minimum latency: req_wvalid rising in IDLE at edge t gives req_wready visible from cycle t+1 if m_wready=1.
REQ-014 Changes to req_wvalid of non-owners while busy SHALL be ignored.
REQ-015 A req_wvalid from the owner that drops in DATA before handshake is a protocol violation; the FSM SHALL stay in DATA.
REQ-016 When N_REQ is not a power of two, rr_ptr SHALL wrap from N_REQ-1 to 0.

Reset
REQ-017 On rst at a clock edge, the block SHALL set the following, overriding any in-flight transfer:
- state = IDLE, rr_ptr = 0, grant_id = 0.
- timeout counter = 0, err_cnt = 0.
REQ-018 While rst is high, and in the cycle after, all valid/ready outputs SHALL be 0; an aborted transfer is not resumed and requesters must re-present it.

Structure
REQ-019 Package axi_arb_pkg SHALL hold the state_t enum, RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-020 Sub-module rr_arbiter (inputs: request vector and pointer; outputs: one-hot grant and index; combinational) SHALL perform selection; FSM, muxing and counters stay in axi_wr_arbiter.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Requester 0 alone writes 32'hDEADBEEF, slave holds wready=1 and returns bvalid 2 cycles later with OKAY -> m_wdata=32'hDEADBEEF for one beat, req_bvalid[0] with bresp=00, busy back to 0.
- All 4 requesters assert wvalid continuously from reset -> grants in order 0,1,2,3,0; no requester starved.
- Slave never asserts bvalid -> after 255 RESP cycles, req_bvalid[g]=1 with bresp=10 and err_cnt=1; repeat 256 times -> err_cnt stays 255.
- Requester 2 is owner in RESP while requester 1 raises wvalid -> req_wready[1] and req_bvalid[1] stay 0 until requester 2's B handshake; then requester 1 is granted.
- rst pulsed for 1 cycle during DATA with m_wready=0 -> next cycle state IDLE, m_wvalid=0, rr_ptr=0, grant goes to the lowest-index active requester.
